// File: rtl/systolic_feed_ctrl.sv
// Operand-feed sequencer for an N x M systolic MAC array: evenly spaced load
// beats, diagonal start-enable wavefront build-up, then a max(N,M)-beat drain.
module systolic_feed_ctrl #(
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int K_W = 8,
    parameter int GAP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    input  logic           stall,
    input  logic           abort,
    output logic           load,
    output logic [N-1:0]   A_start_en,
    output logic [M-1:0]   B_start_en,
    output logic [K_W-1:0] beat_idx,
    output logic           drain,
    output logic           busy,
    output logic           done
);

    localparam int D  = (N > M) ? N : M;
    localparam int DW = $clog2(D + 1);
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [K_W-1:0] beat_cnt_r, beat_cnt_s;
    logic [K_W-1:0] k_len_r, k_len_s;
    logic [DW-1:0]  drain_cnt_r, drain_cnt_s;
    logic [GW-1:0]  gap_cnt_r, gap_cnt_s;
    logic [N-1:0]   a_en_r, a_en_s;
    logic [M-1:0]   b_en_r, b_en_s;
    logic           load_s;
    logic           shift_in_s;

    // Next-state, counter and wavefront computation; abort overrides stall and start.
    always_comb begin
        state_s     = state_r;
        beat_cnt_s  = beat_cnt_r;
        k_len_s     = k_len_r;
        drain_cnt_s = drain_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        a_en_s      = a_en_r;
        b_en_s      = b_en_r;
        load_s      = 1'b0;
        shift_in_s  = (state_r == FEED);
        if (abort) begin
            state_s     = IDLE;
            beat_cnt_s  = {K_W{1'b0}};
            k_len_s     = {K_W{1'b0}};
            drain_cnt_s = {DW{1'b0}};
            gap_cnt_s   = {GW{1'b0}};
            a_en_s      = {N{1'b0}};
            b_en_s      = {M{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        beat_cnt_s  = {K_W{1'b0}};
                        drain_cnt_s = {DW{1'b0}};
                        gap_cnt_s   = {GW{1'b0}};
                        k_len_s     = k_len;
                        state_s     = (k_len != {K_W{1'b0}}) ? FEED : DONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FEED, DRAIN: begin
                    if (stall) begin
                        state_s = state_r;
                    end else if (gap_cnt_r != {GW{1'b0}}) begin
                        gap_cnt_s = gap_cnt_r - GW'(1);
                    end else begin
                        // A beat: the wavefront advances one diagonal step.
                        load_s    = 1'b1;
                        gap_cnt_s = GW'(GAP);
                        a_en_s    = (a_en_r << 1) | N'(shift_in_s);
                        b_en_s    = (b_en_r << 1) | M'(shift_in_s);
                        if (state_r == FEED) begin
                            if (beat_cnt_r == k_len_r - K_W'(1)) begin
                                state_s     = DRAIN;
                                beat_cnt_s  = {K_W{1'b0}};
                                drain_cnt_s = {DW{1'b0}};
                            end else begin
                                beat_cnt_s = beat_cnt_r + K_W'(1);
                            end
                        end else begin
                            if (drain_cnt_r == DW'(D - 1)) begin
                                state_s     = DONE;
                                drain_cnt_s = {DW{1'b0}};
                            end else begin
                                drain_cnt_s = drain_cnt_r + DW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, counter and enable registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            beat_cnt_r  <= {K_W{1'b0}};
            k_len_r     <= {K_W{1'b0}};
            drain_cnt_r <= {DW{1'b0}};
            gap_cnt_r   <= {GW{1'b0}};
            a_en_r      <= {N{1'b0}};
            b_en_r      <= {M{1'b0}};
        end else begin
            state_r     <= state_s;
            beat_cnt_r  <= beat_cnt_s;
            k_len_r     <= k_len_s;
            drain_cnt_r <= drain_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            a_en_r      <= a_en_s;
            b_en_r      <= b_en_s;
        end
    end

    assign load       = load_s;
    assign A_start_en = a_en_r;
    assign B_start_en = b_en_r;
    assign beat_idx   = (state_r == FEED) ? beat_cnt_r : {K_W{1'b0}};
    assign drain      = (state_r == DRAIN);
    assign busy       = (state_r != IDLE);
    assign done       = (state_r == DONE);

endmodule
